// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - coprocessor-0: SR, Cause, EPC, PRId, Count/Compare and exception arbitration
module cp0_unit #(
  parameter int          NUM_HWINT = 6,
  parameter bit          TIMER_EN  = 1'b1,
  parameter logic [31:0] PRID_VAL  = 32'h0000_4D49
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           a1,
  input  logic [4:0]           a2,
  input  logic [31:0]          din,
  input  logic                 we,
  input  logic [31:0]          pc_m,
  input  logic                 bd_m,
  input  logic [4:0]           exc_code_m,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic                 exl_clr,
  output logic                 int_req,
  output logic [31:0]          epc,
  output logic [31:0]          dout,
  output logic                 timer_irq
);

  logic [NUM_HWINT-1:0] im;
  logic [NUM_HWINT-1:0] ip;
  logic [NUM_HWINT-1:0] ip_eff;
  logic                 exl;
  logic                 ie;
  logic                 bd;
  logic                 ti;
  logic [4:0]           exc_code;
  logic [31:0]          epc_q;
  logic [31:0]          count;
  logic [31:0]          compare;
  logic [31:0]          sr;
  logic [31:0]          cause;
  logic [31:0]          epc_target;
  logic                 irq;
  logic                 exc;
  logic                 wr;

  // Timer shares the top interrupt line with the highest external request
  always_comb begin
    ip_eff = hwint;
    ip_eff[NUM_HWINT-1] = hwint[NUM_HWINT-1] | (TIMER_EN & ti);
  end

  assign irq        = (|(ip_eff & im)) & ie & ~exl;
  assign exc        = (exc_code_m != 5'd0) & ~exl;
  assign int_req    = (irq | exc) & ~reset;
  assign wr         = we & ~int_req;
  assign epc_target = (bd_m ? pc_m - 32'd4 : pc_m) & 32'hFFFF_FFFC;
  assign epc        = epc_q;
  assign timer_irq  = ti;

  always_comb begin
    sr = 32'd0;
    sr[10 +: NUM_HWINT] = im;
    sr[1] = exl;
    sr[0] = ie;
    cause = 32'd0;
    cause[31] = bd;
    cause[30] = ti;
    cause[10 +: NUM_HWINT] = ip;
    cause[6:2] = exc_code;
  end

  always_comb begin
    dout = 32'd0;
    case (a1)
      5'd9:    dout = TIMER_EN ? count : 32'd0;
      5'd11:   dout = TIMER_EN ? compare : 32'd0;
      5'd12:   dout = sr;
      5'd13:   dout = cause;
      5'd14:   dout = epc_q;
      5'd15:   dout = PRID_VAL;
      default: dout = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      ip       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ti       <= 1'b0;
      exc_code <= 5'd0;
      epc_q    <= 32'd0;
      count    <= 32'd0;
      compare  <= 32'd0;
    end else begin
      ip <= ip_eff;
      if (TIMER_EN) begin
        count <= (wr && a2 == 5'd9) ? din : count + 32'd1;
        // A Compare write acknowledges the timer even on a coincident match
        if (wr && a2 == 5'd11) begin
          compare <= din;
          ti      <= 1'b0;
        end else if (count == compare && compare != 32'd0) begin
          ti <= 1'b1;
        end
      end
      if (int_req) begin
        exl      <= 1'b1;
        exc_code <= irq ? 5'd0 : exc_code_m;
        bd       <= bd_m;
        epc_q    <= epc_target;
      end else begin
        if (wr && a2 == 5'd12) begin
          im  <= din[10 +: NUM_HWINT];
          exl <= din[1];
          ie  <= din[0];
        end
        if (wr && a2 == 5'd14) epc_q <= din & 32'hFFFF_FFFC;
        if (exl_clr) exl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - self-checking bench for cp0_unit against a word-level reference model
module tb_cp0_unit;

  localparam int          NH   = 6;
  localparam logic [31:0] PRID = 32'h0000_4D49;
  localparam logic [31:0] IM_MASK = 32'h0000_FC00;

  logic          clk;
  logic          reset;
  logic [4:0]    a1;
  logic [4:0]    a2;
  logic [31:0]   din;
  logic          we;
  logic [31:0]   pc_m;
  logic          bd_m;
  logic [4:0]    exc_code_m;
  logic [NH-1:0] hwint;
  logic          exl_clr;
  logic          int_req;
  logic [31:0]   epc;
  logic [31:0]   dout;
  logic          timer_irq;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;

  cp0_unit #(.NUM_HWINT(NH), .TIMER_EN(1'b1), .PRID_VAL(PRID)) dut (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .din(din), .we(we),
    .pc_m(pc_m), .bd_m(bd_m), .exc_code_m(exc_code_m), .hwint(hwint),
    .exl_clr(exl_clr), .int_req(int_req), .epc(epc), .dout(dout),
    .timer_irq(timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_ipe();
    logic [31:0] v;
    v = 32'(hwint);
    if (m_cause[30]) v = v | (32'd1 << (NH - 1));
    return v;
  endfunction

  function automatic logic m_irq();
    return (((m_ipe() << 10) & m_sr & IM_MASK) != 32'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_int();
    return !reset && (m_irq() || (exc_code_m != 5'd0 && !m_sr[1]));
  endfunction

  function automatic logic [31:0] m_dout();
    case (a1)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  // Checks every output against the model, then advances model and DUT by one edge
  task automatic step();
    logic [31:0] n_sr, n_cause, n_epc, n_count, n_compare, ipe;
    logic        n_ti, n_bd, take, irq_now;
    logic [4:0]  n_code;
    #1;
    check("int_req", 32'(int_req), 32'(m_int()));
    check("dout", dout, m_dout());
    check("epc", epc, m_epc);
    check("timer_irq", 32'(timer_irq), 32'(m_cause[30]));
    take = m_int();
    irq_now = m_irq();
    ipe = m_ipe();
    n_sr = m_sr; n_epc = m_epc; n_compare = m_compare;
    n_ti = m_cause[30]; n_bd = m_cause[31]; n_code = m_cause[6:2];
    n_count = m_count + 32'd1;
    if (m_count == m_compare && m_compare != 32'd0) n_ti = 1'b1;
    if (we && !take) begin
      case (a2)
        5'd9:  n_count = din;
        5'd11: begin n_compare = din; n_ti = 1'b0; end
        5'd12: n_sr = din & (IM_MASK | 32'd3);
        5'd14: n_epc = din & 32'hFFFF_FFFC;
        default: ;
      endcase
    end
    if (take) begin
      n_sr = n_sr | 32'd2;
      n_code = irq_now ? 5'd0 : exc_code_m;
      n_bd = bd_m;
      n_epc = (bd_m ? pc_m - 32'd4 : pc_m) & 32'hFFFF_FFFC;
    end else if (exl_clr) begin
      n_sr = n_sr & ~32'd2;
    end
    n_cause = (32'(n_bd) << 31) | (32'(n_ti) << 30) | ((ipe << 10) & IM_MASK) | (32'(n_code) << 2);
    if (reset) begin
      n_sr = 0; n_cause = 0; n_epc = 0; n_count = 0; n_compare = 0;
    end
    @(posedge clk);
    m_sr = n_sr; m_cause = n_cause; m_epc = n_epc; m_count = n_count; m_compare = n_compare;
    #1;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    we = 1'b1; a2 = r; din = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    int n;
    logic [4:0] regs [7];
    regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
    reset = 1'b1; a1 = 5'd15; a2 = 5'd0; din = 0; we = 0; pc_m = 0; bd_m = 0;
    exc_code_m = 0; hwint = '0; exl_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0;
    reset = 1'b0;
    hwint = '1;
    #1;
    check("reset_prid", dout, PRID);
    check("reset_int_req", 32'(int_req), 32'd0);
    check("reset_timer_irq", 32'(timer_irq), 32'd0);
    a1 = 5'd12; #1;
    check("reset_sr", dout, 32'd0);
    check("reset_epc", epc, 32'd0);

    // hardware interrupt on IP[12]
    hwint = '0;
    mtc0(5'd12, 32'h0000_FC01);
    hwint = 6'b000100; pc_m = 32'h3010; bd_m = 0; #1;
    check("hw_int_req", 32'(int_req), 32'd1);
    step();
    check("hw_sr", dout, 32'h0000_FC03);
    a1 = 5'd13; #1;
    check("hw_cause", dout, 32'h0000_1000);
    check("hw_epc", epc, 32'h3010);
    check("hw_int_req_masked", 32'(int_req), 32'd0);

    // overflow in a delay slot
    hwint = '0; exl_clr = 1; step(); exl_clr = 0;
    exc_code_m = 5'd12; bd_m = 1; pc_m = 32'h3024; #1;
    check("ov_int_req", 32'(int_req), 32'd1);
    step();
    exc_code_m = 0; bd_m = 0; #1;
    check("ov_cause", dout, 32'h8000_0030);
    check("ov_epc", epc, 32'h3020);

    // interrupt beats simultaneous exception, then eret re-exposes the request
    exl_clr = 1; step(); exl_clr = 0;
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'b000001; exc_code_m = 5'd4; pc_m = 32'h3100;
    step();
    exc_code_m = 0; #1;
    check("prio_cause", dout, 32'h0000_0400);
    exl_clr = 1; step(); exl_clr = 0; #1;
    check("eret_reassert", 32'(int_req), 32'd1);
    step();
    hwint = '0; exl_clr = 1; step(); exl_clr = 0;

    // timer
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd5);
    n = 0;
    while (!timer_irq && n < 20) begin step(); n++; end
    check("timer_rise_cycles", 32'(n), 32'd6);
    check("timer_int_req", 32'(int_req), 32'd1);
    step();
    mtc0(5'd11, 32'd50); #1;
    check("timer_clear", 32'(timer_irq), 32'd0);

    // mtc0 EPC dropped under int_req, Cause not writable
    exl_clr = 1; step(); exl_clr = 0;
    exc_code_m = 5'd8; pc_m = 32'h3200; bd_m = 0;
    mtc0(5'd14, 32'hDEAD_BEEF);
    exc_code_m = 0;
    check("epc_write_dropped", epc, 32'h3200);
    mtc0(5'd13, 32'hFFFF_FFFF);
    a1 = 5'd13; #1;
    check("cause_readonly", dout, 32'h0000_0020);

    // reset overrides a pending exception
    exl_clr = 1; step(); exl_clr = 0;
    exc_code_m = 5'd8; reset = 1; #1;
    check("reset_kills_int_req", 32'(int_req), 32'd0);
    step();
    reset = 0; exc_code_m = 0; a1 = 5'd12; #1;
    check("reset_mid_sr", dout, 32'd0);
    check("reset_mid_epc", epc, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      a1         = regs[$urandom_range(0, 6)];
      a2         = regs[$urandom_range(0, 6)];
      if (a1 == 5'd0) a1 = 5'($urandom);
      if (a2 == 5'd0) a2 = 5'($urandom);
      we         = ($urandom_range(0, 3) == 0);
      din        = $urandom;
      if (a2 == 5'd11) din = m_count + 32'($urandom_range(0, 8));
      if (a2 == 5'd12) din = din | 32'd1;
      pc_m       = $urandom;
      bd_m       = 1'($urandom);
      exc_code_m = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      hwint      = ($urandom_range(0, 2) == 0) ? NH'($urandom) : '0;
      exl_clr    = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
